// File: rtl/clk_div_pkg.sv
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared types and constants for the programmable clock divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } div_state_t;

    // Smallest legal half-period; a requested 0 is raised to this.
    localparam int CLK_DIV_MIN_HALF = 1;

endpackage

`default_nettype wire

// File: rtl/half_period_counter.sv
// ============================================================================
// Module      : half_period_counter
// Description : Counts clk_in cycles within one clk_out half-period and flags
//               the last cycle of it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module half_period_counter
    import clk_div_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             run,
    input  logic             restart,
    input  logic [CNT_W-1:0] active_half,
    output logic             terminal
);

    logic [CNT_W-1:0] r_count;

    // active_half is never 0, so the subtraction cannot wrap.
    assign terminal = run && (r_count == (active_half - CNT_W'(1)));

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (!run || restart || terminal) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/prog_clk_div.sv
// ============================================================================
// Module      : prog_clk_div
// Description : Runtime-programmable clock divider with glitch-free ratio
//               changes and clean start/stop (clk_out always parks low).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_clk_div
    import clk_div_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int RESET_HALF = 1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             clk_out,
    output logic             tick,
    output logic             running,
    output logic [CNT_W-1:0] active_half
);

    div_state_t       r_state;
    logic             r_clk_out;
    logic             r_tick;
    logic             r_running;
    logic [CNT_W-1:0] r_active_half;
    logic             r_pend_valid;
    logic [CNT_W-1:0] r_pend_half;

    logic             w_run;
    logic             w_terminal;
    logic             w_capture;
    logic             w_apply;
    logic             w_level_next;
    logic [CNT_W-1:0] w_cfg_clamped;

    assign w_run         = (r_state != IDLE);
    assign w_capture     = cfg_valid && !r_pend_valid;
    // While running, a new ratio only lands on a toggle so no half-period is cut short.
    assign w_apply       = r_pend_valid && ((r_state == IDLE) || w_terminal);
    assign w_level_next  = r_clk_out ^ w_terminal;
    assign w_cfg_clamped = (cfg_half == '0) ? CNT_W'(CLK_DIV_MIN_HALF) : cfg_half;

    half_period_counter #(
        .CNT_W (CNT_W)
    ) u_half_period_counter (
        .clk_in      (clk_in),
        .rst         (rst),
        .run         (w_run),
        .restart     (w_apply),
        .active_half (r_active_half),
        .terminal    (w_terminal)
    );

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_clk_out     <= 1'b0;
            r_tick        <= 1'b0;
            r_running     <= 1'b0;
            r_active_half <= CNT_W'(RESET_HALF);
            r_pend_valid  <= 1'b0;
            r_pend_half   <= '0;
        end else begin
            r_tick <= w_terminal;

            if (w_capture) begin
                r_pend_valid <= 1'b1;
                r_pend_half  <= w_cfg_clamped;
            end else if (w_apply) begin
                r_pend_valid  <= 1'b0;
                r_active_half <= r_pend_half;
            end

            if (w_terminal) begin
                r_clk_out <= ~r_clk_out;
            end

            // The stop decision looks at the level after any same-cycle toggle.
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                RUN: begin
                    if (!en) begin
                        if (w_level_next) begin
                            r_state <= STOPPING;
                        end else begin
                            r_state   <= IDLE;
                            r_running <= 1'b0;
                        end
                    end
                end
                STOPPING: begin
                    if (en) begin
                        r_state <= RUN;
                    end else if (w_terminal) begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready   = ~r_pend_valid;
    assign clk_out     = r_clk_out;
    assign tick        = r_tick;
    assign running     = r_running;
    assign active_half = r_active_half;

endmodule

`default_nettype wire

// File: tb/tb_prog_clk_div.sv
// ============================================================================
// Module      : tb_prog_clk_div
// Description : Self-checking bench for prog_clk_div: cycle model plus
//               directed waveform-timing checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_prog_clk_div;

    localparam int CNT_W      = 16;
    localparam int RESET_HALF = 1;

    logic             clk_in = 1'b0;
    logic             rst;
    logic             en;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_half;
    logic             clk_out;
    logic             tick;
    logic             running;
    logic [CNT_W-1:0] active_half;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_in = ~clk_in;

    prog_clk_div #(
        .CNT_W      (CNT_W),
        .RESET_HALF (RESET_HALF)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_half    (cfg_half),
        .clk_out     (clk_out),
        .tick        (tick),
        .running     (running),
        .active_half (active_half)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: mode 0=idle 1=run 2=stopping; m_left = edges remaining in this level.
    int  m_mode  = 0;
    bit  m_level = 1'b0;
    bit  m_tick  = 1'b0;
    int  m_half  = RESET_HALF;
    int  m_left  = 0;
    int  m_pend[$];

    always @(posedge clk_in or posedge rst) begin : model
        bit ready_pre;
        bit toggle;
        if (rst) begin
            m_mode  = 0;
            m_level = 1'b0;
            m_tick  = 1'b0;
            m_half  = RESET_HALF;
            m_left  = 0;
            m_pend.delete();
        end else begin
            ready_pre = (m_pend.size() == 0);
            toggle    = (m_mode != 0) && (m_left == 1);
            m_tick    = toggle;
            if (m_mode == 0) begin
                if (m_pend.size() != 0) m_half = m_pend.pop_front();
                if (en) begin
                    m_mode = 1;
                    m_left = m_half;
                end
            end else begin
                if (toggle) begin
                    m_level = !m_level;
                    if (m_pend.size() != 0) m_half = m_pend.pop_front();
                    m_left = m_half;
                end else begin
                    m_left = m_left - 1;
                end
                if (m_mode == 1) begin
                    if (!en) m_mode = m_level ? 2 : 0;
                end else begin
                    if (en) m_mode = 1;
                    else if (toggle) m_mode = 0;
                end
            end
            if (cfg_valid && ready_pre) m_pend.push_back((cfg_half == '0) ? 1 : int'(cfg_half));
        end
    end

    always @(negedge clk_in) begin
        check("clk_out",     int'(clk_out),     int'(m_level));
        check("tick",        int'(tick),        int'(m_tick));
        check("running",     int'(running),     int'(m_mode != 0));
        check("cfg_ready",   int'(cfg_ready),   int'(m_pend.size() == 0));
        check("active_half", int'(active_half), m_half);
    end

    // Toggle timestamps in clk_in cycles, for hand-computed waveform checks.
    int   cyc = 0;
    int   tq[$];
    logic prev_clk = 1'b0;

    always @(posedge clk_in) begin
        #1;
        cyc++;
        if (clk_out !== prev_clk) begin
            tq.push_back(cyc);
            prev_clk = clk_out;
        end
    end

    function automatic int tdiff(input int i);
        if (i < 1 || i >= tq.size()) return -1;
        return tq[i] - tq[i-1];
    endfunction

    task automatic cyc_n(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic wait_level(input logic v, input string name);
        int g = 0;
        do begin
            @(negedge clk_in);
            g++;
        end while (clk_out !== v && g < 200);
        check(name, int'(clk_out === v), 1);
    endtask

    task automatic wait_idle(input string name);
        int g = 0;
        while (running !== 1'b0 && g < 200) begin
            @(negedge clk_in);
            g++;
        end
        check(name, int'(running === 1'b0), 1);
    endtask

    // Holds cfg_valid until a negedge shows cfg_ready, then drops it after the capture edge.
    task automatic write_cfg(input int h);
        int g = 0;
        @(negedge clk_in);
        cfg_valid = 1'b1;
        cfg_half  = CNT_W'(h);
        while (!cfg_ready && g < 200) begin
            @(negedge clk_in);
            g++;
        end
        check("cfg_accept", int'(g < 200), 1);
        @(negedge clk_in);
        cfg_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_half = '0;
        cyc_n(3);
        check("rst_clk_out",     int'(clk_out),     0);
        check("rst_cfg_ready",   int'(cfg_ready),   1);
        check("rst_active_half", int'(active_half), RESET_HALF);
        check("rst_running",     int'(running),     0);
        check("rst_tick",        int'(tick),        0);
        rst = 1'b0;
        cyc_n(2);

        // half=1: clk_in/2, tick every cycle
        en = 1'b1;
        cyc_n(1);
        check("h1_running", int'(running), 1);
        check("h1_first_low", int'(clk_out), 0);
        cyc_n(1);
        check("h1_first_high", int'(clk_out), 1);
        check("h1_tick_a", int'(tick), 1);
        cyc_n(1);
        check("h1_second_low", int'(clk_out), 0);
        for (int i = 0; i < 4; i++) begin
            cyc_n(1);
            check("h1_tick_cont", int'(tick), 1);
        end
        en = 1'b0;
        wait_idle("h1_stop");
        check("h1_park_low", int'(clk_out), 0);

        // half=5 programmed in IDLE
        write_cfg(5);
        cyc_n(1);
        check("h5_loaded", int'(active_half), 5);
        tq.delete();
        en = 1'b1;
        k = 0;
        do begin
            @(negedge clk_in);
            k++;
        end while (clk_out == 1'b0 && k < 50);
        check("h5_first_rise", k, 6);
        cyc_n(25);
        check("h5_high", tdiff(1), 5);
        check("h5_low",  tdiff(2), 5);

        // 5 -> 2 mid-half, second write 3 stalls until the apply
        wait_level(1'b0, "h52_sync_low");
        tq.delete();
        wait_level(1'b1, "h52_sync_high");
        cyc_n(1);
        cfg_valid = 1'b1;
        cfg_half  = CNT_W'(2);
        cyc_n(1);
        check("h52_stall", int'(cfg_ready), 0);
        cfg_half = CNT_W'(3);
        k = 0;
        while (!cfg_ready && k < 50) begin
            @(negedge clk_in);
            k++;
        end
        check("h52_second_accept", int'(k < 50), 1);
        @(negedge clk_in);
        cfg_valid = 1'b0;
        cyc_n(20);
        check("h52_old_half_done", tdiff(1), 5);
        check("h52_new_low",       tdiff(2), 2);
        check("h52_third_high",    tdiff(3), 3);
        check("h52_active",        int'(active_half), 3);

        // stop while high at half=4
        write_cfg(4);
        cyc_n(10);
        wait_level(1'b0, "h4_sync_low");
        tq.delete();
        wait_level(1'b1, "h4_sync_high");
        en = 1'b0;
        cyc_n(8);
        check("h4_stop_high_len", tdiff(1), 4);
        check("h4_stop_edges",    tq.size(), 2);
        check("h4_stop_running",  int'(running), 0);
        check("h4_stop_park",     int'(clk_out), 0);

        // re-enable during STOPPING: waveform continues without a gap
        tq.delete();
        en = 1'b1;
        wait_level(1'b1, "h4_restart_high");
        cyc_n(1);
        en = 1'b0;
        cyc_n(1);
        en = 1'b1;
        cyc_n(20);
        check("h4_resume_a", tdiff(1), 4);
        check("h4_resume_b", tdiff(2), 4);
        check("h4_resume_c", tdiff(3), 4);
        en = 1'b0;
        wait_idle("h4_final_stop");

        // zero clamps to one
        write_cfg(0);
        cyc_n(1);
        check("clamp_zero", int'(active_half), 1);

        // async reset mid-high-phase with a pending config
        write_cfg(6);
        cyc_n(1);
        en = 1'b1;
        wait_level(1'b1, "rst_sync_high");
        cyc_n(2);
        write_cfg(9);
        check("pre_rst_high",    int'(clk_out),   1);
        check("pre_rst_pending", int'(cfg_ready), 0);
        #3 rst = 1'b1;
        #1;
        check("arst_clk_out",     int'(clk_out),     0);
        check("arst_active_half", int'(active_half), RESET_HALF);
        check("arst_cfg_ready",   int'(cfg_ready),   1);
        check("arst_running",     int'(running),     0);
        check("arst_tick",        int'(tick),        0);
        @(negedge clk_in);
        en  = 1'b0;
        rst = 1'b0;
        cyc_n(3);
        check("pend_discarded", int'(active_half), RESET_HALF);
        check("post_rst_idle",  int'(running),     0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
